sc_gamefsm_multilevel: RTL and testbench

//  Parametrised Frogger game controller. Owns lives counter, level counter, house-occupancy bitmap
//  and inter-level/end-of-game timer internally. Sits between input debouncers, collision/house

---
 rtl/sc_gamefsm_multilevel.sv | 207 ++++++++++++++++++++
 tb/tb_sc_gamefsm_multilevel.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sc_gamefsm_multilevel.sv
// Frogger game controller: lives, levels, house occupancy and the inter-level/end-of-game timer.
// The outputs are decoded from registered state only, and the strobes to the lane/score datapath are active-low.
module sc_gamefsm_multilevel #(
  parameter int N_HOUSES     = 4,
  parameter int HIDX_W       = (N_HOUSES > 1) ? $clog2(N_HOUSES) : 1,
  parameter int LIFE_W       = 2,
  parameter int INIT_LIVES   = 3,
  parameter int MAX_LIVES    = 3,
  parameter int LVL_W        = 2,
  parameter int MAX_LEVEL    = 3,
  parameter int TRANS_CYCLES = 50000000,
  parameter int TMR_W        = 26
) (
  input  logic                SC_GAMEFSM_CLOCK_50,
  input  logic                SC_GAMEFSM_RESET_InLow,
  input  logic                SC_GAMEFSM_start_InLow,
  input  logic                SC_GAMEFSM_pause_InLow,
  input  logic                SC_GAMEFSM_hit_InLow,
  input  logic                SC_GAMEFSM_houseValid_InHigh,
  input  logic [HIDX_W-1:0]   SC_GAMEFSM_houseIdx_InBUS,
  input  logic                SC_GAMEFSM_coin_InLow,
  output logic [3:0]          SC_GAMEFSM_state_OutBUS,
  output logic [LIFE_W-1:0]   SC_GAMEFSM_lives_OutBUS,
  output logic [LVL_W-1:0]    SC_GAMEFSM_level_OutBUS,
  output logic [N_HOUSES-1:0] SC_GAMEFSM_houses_OutBUS,
  output logic                SC_GAMEFSM_LoadGame_OutLow,
  output logic                SC_GAMEFSM_ClearPoint_OutLow,
  output logic                SC_GAMEFSM_SpeedClear_OutLow,
  output logic                SC_GAMEFSM_gameOver_OutHigh,
  output logic                SC_GAMEFSM_win_OutHigh
);

  localparam int HSPAN = 1 << HIDX_W;
  localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(TRANS_CYCLES - 1);
  localparam logic [LIFE_W-1:0] LIVES_INIT = LIFE_W'(INIT_LIVES);
  localparam logic [LIFE_W-1:0] LIVES_MAX  = LIFE_W'(MAX_LIVES);
  localparam logic [LVL_W-1:0]  LVL_LAST   = LVL_W'(MAX_LEVEL);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_PLAY     = 4'd1,
    S_LOSELIFE = 4'd2,
    S_HOUSE    = 4'd3,
    S_COIN     = 4'd4,
    S_LEVELUP  = 4'd5,
    S_TRANS    = 4'd6,
    S_GAMEOVER = 4'd7,
    S_WIN      = 4'd8,
    S_PAUSE    = 4'd9
  } state_t;

  typedef struct packed {
    logic loadGame_n;
    logic clearPoint_n;
    logic speedClear_n;
    logic gameOver;
    logic win;
  } ctrl_t;

  state_t              state, stateNxt;
  logic [LIFE_W-1:0]   lives, livesNxt;
  logic [LVL_W-1:0]    level, levelNxt;
  logic [N_HOUSES-1:0] houses, housesNxt;
  logic [TMR_W-1:0]    timer, timerNxt;
  ctrl_t               ctrl;

  // An out-of-range index decodes to no bit at all and is treated like an occupied house.
  logic [HSPAN-1:0]    idxOneHot;
  logic [N_HOUSES-1:0] houseBit;
  logic                houseBad;
  logic                timerDone;

  assign idxOneHot = HSPAN'(1) << SC_GAMEFSM_houseIdx_InBUS;
  assign houseBit  = idxOneHot[N_HOUSES-1:0];
  assign houseBad  = (houseBit == '0) || ((houseBit & houses) != '0);
  assign timerDone = (timer == TMR_LAST);

  always_ff @(posedge SC_GAMEFSM_CLOCK_50) begin
    if (!SC_GAMEFSM_RESET_InLow) begin
      state  <= S_IDLE;
      lives  <= '0;
      level  <= '0;
      houses <= '0;
      timer  <= '0;
    end else begin
      state  <= stateNxt;
      lives  <= livesNxt;
      level  <= levelNxt;
      houses <= housesNxt;
      timer  <= timerNxt;
    end
  end

  always_comb begin
    stateNxt  = state;
    livesNxt  = lives;
    levelNxt  = level;
    housesNxt = houses;
    timerNxt  = timer;
    case (state)
      S_IDLE: begin
        if (!SC_GAMEFSM_start_InLow) begin
          livesNxt  = LIVES_INIT;
          levelNxt  = '0;
          housesNxt = '0;
          timerNxt  = '0;
          stateNxt  = S_TRANS;
        end
      end
      S_TRANS: begin
        if (timerDone) begin
          timerNxt = '0;
          stateNxt = S_PLAY;
        end else begin
          timerNxt = timer + TMR_W'(1);
        end
      end
      S_PLAY: begin
        if (!SC_GAMEFSM_pause_InLow)      stateNxt = S_PAUSE;
        else if (!SC_GAMEFSM_hit_InLow)   stateNxt = S_LOSELIFE;
        else if (SC_GAMEFSM_houseValid_InHigh) begin
          if (houseBad) begin
            stateNxt = S_LOSELIFE;
          end else begin
            housesNxt = houses | houseBit;
            stateNxt  = S_HOUSE;
          end
        end
        else if (!SC_GAMEFSM_coin_InLow)  stateNxt = S_COIN;
      end
      S_PAUSE: begin
        if (!SC_GAMEFSM_pause_InLow) stateNxt = S_PLAY;
      end
      S_LOSELIFE: begin
        if (lives != '0) livesNxt = lives - LIFE_W'(1);
        if (lives <= LIFE_W'(1)) begin
          timerNxt = '0;
          stateNxt = S_GAMEOVER;
        end else begin
          stateNxt = S_PLAY;
        end
      end
      S_HOUSE: begin
        stateNxt = (houses == '1) ? S_LEVELUP : S_PLAY;
      end
      S_COIN: begin
        if (lives < LIVES_MAX) livesNxt = lives + LIFE_W'(1);
        stateNxt = S_PLAY;
      end
      S_LEVELUP: begin
        housesNxt = '0;
        timerNxt  = '0;
        if (level == LVL_LAST) begin
          stateNxt = S_WIN;
        end else begin
          levelNxt = level + LVL_W'(1);
          stateNxt = S_TRANS;
        end
      end
      S_GAMEOVER, S_WIN: begin
        // Lives and level are left alone so the score display survives until the next start.
        if (timerDone) begin
          timerNxt = '0;
          stateNxt = S_IDLE;
        end else begin
          timerNxt = timer + TMR_W'(1);
        end
      end
      default: stateNxt = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl = '{loadGame_n: 1'b1, clearPoint_n: 1'b1, speedClear_n: 1'b1, gameOver: 1'b0, win: 1'b0};
    case (state)
      S_IDLE:     ctrl.speedClear_n = 1'b0;
      S_TRANS: begin
        ctrl.speedClear_n = 1'b0;
        ctrl.loadGame_n   = (timer != '0);
        ctrl.clearPoint_n = !timerDone;
      end
      S_PAUSE:    ctrl.speedClear_n = 1'b0;
      S_LOSELIFE: ctrl.clearPoint_n = 1'b0;
      S_HOUSE:    ctrl.clearPoint_n = 1'b0;
      S_GAMEOVER: begin
        ctrl.speedClear_n = 1'b0;
        ctrl.gameOver     = 1'b1;
      end
      S_WIN: begin
        ctrl.speedClear_n = 1'b0;
        ctrl.win          = 1'b1;
      end
      default: ;
    endcase
  end

  assign SC_GAMEFSM_state_OutBUS      = state;
  assign SC_GAMEFSM_lives_OutBUS      = lives;
  assign SC_GAMEFSM_level_OutBUS      = level;
  assign SC_GAMEFSM_houses_OutBUS     = houses;
  assign SC_GAMEFSM_LoadGame_OutLow   = ctrl.loadGame_n;
  assign SC_GAMEFSM_ClearPoint_OutLow = ctrl.clearPoint_n;
  assign SC_GAMEFSM_SpeedClear_OutLow = ctrl.speedClear_n;
  assign SC_GAMEFSM_gameOver_OutHigh  = ctrl.gameOver;
  assign SC_GAMEFSM_win_OutHigh       = ctrl.win;

endmodule

// File: tb/tb_sc_gamefsm_multilevel.sv
// Directed bench for sc_gamefsm_multilevel with a short transition timer and a two-level game.
module tb_sc_gamefsm_multilevel;

  logic       clk = 1'b0;
  logic       rst_n, start_n, pause_n, hit_n, hv, coin_n;
  logic [1:0] idx;
  logic [3:0] state;
  logic [1:0] lives, level;
  logic [3:0] houses;
  logic       load_n, clrpt_n, spdclr_n, go, win;
  int         checks = 0;
  int         errors = 0;

  sc_gamefsm_multilevel #(
    .N_HOUSES(4), .LIFE_W(2), .INIT_LIVES(3), .MAX_LIVES(3),
    .LVL_W(2), .MAX_LEVEL(1), .TRANS_CYCLES(4), .TMR_W(3)
  ) dut (
    .SC_GAMEFSM_CLOCK_50(clk),
    .SC_GAMEFSM_RESET_InLow(rst_n),
    .SC_GAMEFSM_start_InLow(start_n),
    .SC_GAMEFSM_pause_InLow(pause_n),
    .SC_GAMEFSM_hit_InLow(hit_n),
    .SC_GAMEFSM_houseValid_InHigh(hv),
    .SC_GAMEFSM_houseIdx_InBUS(idx),
    .SC_GAMEFSM_coin_InLow(coin_n),
    .SC_GAMEFSM_state_OutBUS(state),
    .SC_GAMEFSM_lives_OutBUS(lives),
    .SC_GAMEFSM_level_OutBUS(level),
    .SC_GAMEFSM_houses_OutBUS(houses),
    .SC_GAMEFSM_LoadGame_OutLow(load_n),
    .SC_GAMEFSM_ClearPoint_OutLow(clrpt_n),
    .SC_GAMEFSM_SpeedClear_OutLow(spdclr_n),
    .SC_GAMEFSM_gameOver_OutHigh(go),
    .SC_GAMEFSM_win_OutHigh(win)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start from IDLE and walk through the four transition cycles into PLAY.
  task automatic newGame();
    start_n = 1'b0; step(); start_n = 1'b1;
    chk("trans.state0", 32'(state), 6);
    chk("trans.load0", 32'(load_n), 0);
    chk("trans.lives", 32'(lives), 3);
    chk("trans.level", 32'(level), 0);
    step(); chk("trans.load1", 32'(load_n), 1);
    step();
    step(); chk("trans.clrpt", 32'(clrpt_n), 0);
    chk("trans.state3", 32'(state), 6);
    step(); chk("play.state", 32'(state), 1);
    chk("play.clrpt", 32'(clrpt_n), 1);
    chk("play.spdclr", 32'(spdclr_n), 1);
  endtask

  initial begin
    rst_n = 1'b0; start_n = 1'b1; pause_n = 1'b1; hit_n = 1'b1;
    hv = 1'b0; idx = 2'd0; coin_n = 1'b1;
    step(); step();
    chk("rst.state", 32'(state), 0);
    chk("rst.lives", 32'(lives), 0);
    chk("rst.spdclr", 32'(spdclr_n), 0);
    chk("rst.load", 32'(load_n), 1);
    chk("rst.clrpt", 32'(clrpt_n), 1);
    chk("rst.go", 32'(go), 0);
    chk("rst.win", 32'(win), 0);
    rst_n = 1'b1; step();
    chk("idle.hold", 32'(state), 0);

    // reset in the middle of TRANS
    start_n = 1'b0; step(); start_n = 1'b1;
    chk("midtrans.state", 32'(state), 6);
    step(); step();
    rst_n = 1'b0; step(); step();
    chk("midrst.state", 32'(state), 0);
    chk("midrst.lives", 32'(lives), 0);
    chk("midrst.spdclr", 32'(spdclr_n), 0);
    rst_n = 1'b1;

    // three hits run the game out
    newGame();
    for (int i = 0; i < 3; i++) begin
      hit_n = 1'b0; step(); hit_n = 1'b1;
      chk("hit.lose", 32'(state), 2);
      chk("hit.clrpt", 32'(clrpt_n), 0);
      step();
      if (i < 2) begin
        chk("hit.play", 32'(state), 1);
        chk("hit.lives", 32'(lives), 32'(2 - i));
        step();
      end else begin
        chk("go.state", 32'(state), 7);
        chk("go.flag", 32'(go), 1);
        chk("go.lives", 32'(lives), 0);
        chk("go.spdclr", 32'(spdclr_n), 0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(); chk("go.hold", 32'(go), 1);
    end
    step();
    chk("go.idle", 32'(state), 0);
    chk("go.off", 32'(go), 0);
    chk("go.keeplives", 32'(lives), 0);

    // fill all houses on both levels
    newGame();
    for (int lvl = 0; lvl < 2; lvl++) begin
      for (int k = 0; k < 4; k++) begin
        hv = 1'b1; idx = 2'(k); step(); hv = 1'b0;
        chk("house.state", 32'(state), 3);
        chk("house.map", 32'(houses), 32'((1 << (k + 1)) - 1));
        step();
        chk("house.next", 32'(state), (k < 3) ? 1 : 5);
      end
      step();
      if (lvl == 0) begin
        chk("lvlup.trans", 32'(state), 6);
        chk("lvlup.level", 32'(level), 1);
        chk("lvlup.houses", 32'(houses), 0);
        chk("lvlup.load", 32'(load_n), 0);
        step(); step(); step(); step();
        chk("lvlup.play", 32'(state), 1);
      end else begin
        chk("win.state", 32'(state), 8);
        chk("win.flag", 32'(win), 1);
        chk("win.level", 32'(level), 1);
        for (int i = 0; i < 3; i++) begin
          step(); chk("win.hold", 32'(win), 1);
        end
        step();
        chk("win.idle", 32'(state), 0);
        chk("win.off", 32'(win), 0);
        chk("win.keeplevel", 32'(level), 1);
      end
    end

    // occupied house kills, coin bonus saturates
    newGame();
    hv = 1'b1; idx = 2'd2; step(); hv = 1'b0;
    chk("h2.first", 32'(houses), 4);
    step();
    hv = 1'b1; step(); hv = 1'b0;
    chk("h2.second", 32'(state), 2);
    step();
    chk("h2.lives", 32'(lives), 2);
    chk("h2.map", 32'(houses), 4);
    coin_n = 1'b0; step(); coin_n = 1'b1;
    chk("coin.state", 32'(state), 4);
    step(); chk("coin.inc", 32'(lives), 3);
    coin_n = 1'b0; step(); coin_n = 1'b1;
    step(); chk("coin.sat", 32'(lives), 3);

    // hit beats coin
    hit_n = 1'b0; coin_n = 1'b0; step(); hit_n = 1'b1; coin_n = 1'b1;
    chk("prio.state", 32'(state), 2);
    step(); chk("prio.lives", 32'(lives), 2);

    // pause beats hit, and hits are ignored while paused
    pause_n = 1'b0; hit_n = 1'b0; step(); pause_n = 1'b1;
    chk("pause.state", 32'(state), 9);
    chk("pause.spdclr", 32'(spdclr_n), 0);
    step();
    chk("pause.hold", 32'(state), 9);
    chk("pause.lives", 32'(lives), 2);
    hit_n = 1'b1; pause_n = 1'b0; step(); pause_n = 1'b1;
    chk("resume.state", 32'(state), 1);
    chk("resume.lives", 32'(lives), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
